fp_align_shifter: RTL and testbench
===================================

Name: fp_align_shifter

Overview:
- Parametrised, pipelined barrel shifter for the FPU add/sub alignment and normalisation paths.
- Generalises the fixed 26-bit combinational right shift. Width and shift-amount width are parameters.
- Adds logical-right, arithmetic-right and left modes, plus a sticky (lost-bits) flag for rounding.
- Uses valid/ready handshakes with configurable pipeline depth, so it can sit between FPU pipeline stages.

Parameters:
- WIDTH, 26, data width in bits (>= 2).
- SHAMT_W, 8, shift-amount width. Any value of shift_amount is legal.
- NUM_LEVELS, clog2(WIDTH) (derived, not overridable), number of log2 shift levels. Value is 5 for WIDTH=26.
- REG_MASK, 'b00100, NUM_LEVELS-1 bits. Bit i set places a pipeline register after level i (level i shifts by 2^i).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the input beat this cycle.
- fraction  in  WIDTH  operand.
- shift_amount  in  SHAMT_W  shift distance.
- mode  in  2  shift mode: 0 = logical right, 1 = arithmetic right, 2 = logical left, 3 = reserved (treated as 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  shifted value.
- sticky  out  1  OR of all 1-bits shifted out of the word.

Behaviour:
- Reset (nRST low, asynchronous): all stage valids clear and all data/sticky registers go to 0. Outputs are out_valid=0, result=0, sticky=0. in_ready goes to 1 one cycle after reset deasserts.
- Latency: L = 1 + popcount(REG_MASK). The final output register is always present. With the default REG_MASK, L = 2 cycles from accept to out_valid.
- Handshake:
  - Accept: a beat is taken when in_valid && in_ready.
  - Advance enable: adv = !out_valid || out_ready. The whole pipeline advances together on adv.
  - in_ready = adv.
  - Bubbles are not collapsed. A stage's valid follows its predecessor when adv=1 and holds when adv=0.
  - While out_valid && !out_ready, result and sticky must be held stable.
- Throughput: one beat per cycle when out_ready is held at 1.
- Saturation (shift_amount >= WIDTH), resolved at input before level 0:
  - Right logical: result = 0, sticky = |fraction.
  - Right arithmetic: result = all copies of fraction[WIDTH-1]. sticky = 1 if any 1-bit lies among fraction[WIDTH-2:0] or, when the MSB is 0, fraction[WIDTH-1].
  - Left: result = 0, sticky = |fraction.
- Normal shifts: level i applies a shift of 2^i when bit i of shift_amount is set. Each level ORs its discarded bits into a sticky bit carried alongside the data.
  - Arithmetic right: vacated bits are filled with the original sign bit. Sticky counts only discarded bits that are 1.
  - shift_amount = 0: result = fraction and sticky = 0 in all modes.
- Flush:
  - Asserted at an edge, flush clears every stage valid. out_valid is 0 next cycle.
  - Data registers may keep stale values.
  - in_ready is forced to 0 during the flush cycle. An in_valid beat in that cycle is dropped.
  - Flush takes priority over out_ready stalls.
- Reset mid-operation: in-flight beats are discarded. No output pulse is produced after nRST rises until a new beat has been accepted and L cycles have passed.
- Mode 3 behaves exactly as mode 0. No error flag is raised.

Decomposition:
- Package fp_align_pkg:
  - shift_mode_t enum: LSR=0, ASR=1, LSL=2, RSV=3.
  - Function clog2_f.
  - Constant SAT_FILL helpers.
- Sub-module fp_align_level, one per shift level. It is combinational and takes data, sticky_in, mode, sign, enable bit and the static parameter SHIFT.
  - Outputs: data_out, sticky_out.
  - The top instantiates NUM_LEVELS copies with a generate loop. Pipeline registers (data, sticky, mode, sign, remaining shamt bits, valid) are inserted per REG_MASK.

Test Plan (WIDTH=26, default REG_MASK, L=2):
- LSR: fraction=26'h3FFFFFF, shamt=4, mode 0. Result 26'h03FFFFF, sticky=1, out_valid exactly 2 cycles after accept.
- ASR: fraction=26'h2000010, shamt=4, mode 1. Result 26'h3E00001, sticky=0. Repeat with shamt=5: result 26'h3F00000, sticky=1.
- Saturation: shamt=8'd200, fraction=26'h0000001, mode 0. Result 0, sticky=1. Same input with mode 2: result 0, sticky=1.
- LSL: fraction=26'h2000001, shamt=1, mode 2. Result 26'h0000002, sticky=1. With shamt=0: result unchanged, sticky=0.
- Back-pressure: stream 4 beats with shamt 0..3 and fraction=26'h0000F0, holding out_ready=0 for 3 cycles mid-stream.
  - in_ready drops while the output is stalled.
  - Results emerge in order (0F0, 078, 03C, 01E) with no loss or duplication, and result stays stable while stalled.
- Flush/reset: with 2 beats in flight, assert flush for 1 cycle; out_valid stays 0 and nothing emerges. Repeat using an asynchronous nRST pulse mid-cycle; outputs go to 0 immediately.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared types and helpers for the FPU alignment/normalisation barrel shifter.
// Provides the shift mode encoding, a constant clog2, and the saturation fill selector.
package fp_align_pkg;

   typedef enum logic [1:0] {
      LSR = 2'd0,
      ASR = 2'd1,
      LSL = 2'd2,
      RSV = 2'd3
   } shift_mode_t;

   function automatic int unsigned clog2_f(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // An oversized shift leaves only sign copies for ASR, otherwise zeros.
   function automatic logic sat_fills_sign(input shift_mode_t m);
      return m == ASR;
   endfunction

endpackage

// File: rtl/fp_align_level.sv
// One combinational log2 barrel level: shifts by SHIFT when enabled and folds lost 1-bits into sticky.
// Zero latency; no handshake of its own, the parent pipeline owns flow control.
module fp_align_level
   import fp_align_pkg::*;
#(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned SHIFT = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             sticky_in,
   input  logic [1:0]       mode,
   input  logic             sign,
   input  logic             enable,
   output logic [WIDTH-1:0] data_out,
   output logic             sticky_out
);

   always_comb begin
      data_out   = data;
      sticky_out = sticky_in;
      if (enable) begin
         case (shift_mode_t'(mode))
            ASR: begin
               data_out   = {{SHIFT{sign}}, data[WIDTH-1:SHIFT]};
               sticky_out = sticky_in | (|data[SHIFT-1:0]);
            end
            LSL: begin
               data_out   = {data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
               sticky_out = sticky_in | (|data[WIDTH-1:WIDTH-SHIFT]);
            end
            default: begin
               data_out   = {{SHIFT{1'b0}}, data[WIDTH-1:SHIFT]};
               sticky_out = sticky_in | (|data[SHIFT-1:0]);
            end
         endcase
      end
   end

endmodule

// File: rtl/fp_align_shifter.sv
// Pipelined barrel shifter (LSR/ASR/LSL) with sticky output; latency 1 + popcount(REG_MASK).
// Whole pipe advances when the output is empty or taken; flush clears valids and blocks input.
module fp_align_shifter
   import fp_align_pkg::*;
#(
   parameter int unsigned WIDTH    = 26,
   parameter int unsigned SHAMT_W  = 8,
   parameter logic [31:0] REG_MASK = 32'b00100
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   fraction,
   input  logic [SHAMT_W-1:0] shift_amount,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               sticky
);

   localparam int unsigned NUM_LEVELS = clog2_f(WIDTH);

   logic ready_q;
   logic adv;
   logic accept;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && ready_q && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) ready_q <= 1'b0;
      else       ready_q <= 1'b1;
   end

   // Oversized shifts are resolved here so the levels only ever see in-range amounts.
   logic [31:0]           shamt_ext;
   logic                  sat;
   logic                  sign0;
   logic [WIDTH-1:0]      d0;
   logic                  s0;
   logic [NUM_LEVELS-1:0] sh0;

   assign shamt_ext = 32'(shift_amount);
   assign sat       = shamt_ext >= WIDTH;
   assign sign0     = fraction[WIDTH-1];

   always_comb begin
      d0  = fraction;
      s0  = 1'b0;
      sh0 = shamt_ext[NUM_LEVELS-1:0];
      if (sat) begin
         sh0 = '0;
         if (sat_fills_sign(shift_mode_t'(mode))) begin
            d0 = {WIDTH{sign0}};
            s0 = |fraction[WIDTH-2:0];
         end else begin
            d0 = '0;
            s0 = |fraction;
         end
      end
   end

   for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
      logic [WIDTH-1:0]      d_in;
      logic [WIDTH-1:0]      d_out;
      logic                  s_in;
      logic                  s_out;
      logic                  sign_in;
      logic                  vld_in;
      logic [1:0]            mode_in;
      logic [NUM_LEVELS-1:0] sh_in;

      if (i == 0) begin : g_head
         assign d_in    = d0;
         assign s_in    = s0;
         assign sign_in = sign0;
         assign vld_in  = accept;
         assign mode_in = mode;
         assign sh_in   = sh0;
      end else if (REG_MASK[i-1]) begin : g_reg
         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               vld_in  <= 1'b0;
               d_in    <= '0;
               s_in    <= 1'b0;
               sign_in <= 1'b0;
               mode_in <= '0;
               sh_in   <= '0;
            end else begin
               if (flush)    vld_in <= 1'b0;
               else if (adv) vld_in <= g_lvl[i-1].vld_in;
               if (adv) begin
                  d_in    <= g_lvl[i-1].d_out;
                  s_in    <= g_lvl[i-1].s_out;
                  sign_in <= g_lvl[i-1].sign_in;
                  mode_in <= g_lvl[i-1].mode_in;
                  sh_in   <= g_lvl[i-1].sh_in;
               end
            end
         end
      end else begin : g_wire
         assign d_in    = g_lvl[i-1].d_out;
         assign s_in    = g_lvl[i-1].s_out;
         assign sign_in = g_lvl[i-1].sign_in;
         assign vld_in  = g_lvl[i-1].vld_in;
         assign mode_in = g_lvl[i-1].mode_in;
         assign sh_in   = g_lvl[i-1].sh_in;
      end

      fp_align_level #(
         .WIDTH (WIDTH),
         .SHIFT (1 << i)
      ) u_level (
         .data       (d_in),
         .sticky_in  (s_in),
         .mode       (mode_in),
         .sign       (sign_in),
         .enable     (sh_in[i]),
         .data_out   (d_out),
         .sticky_out (s_out)
      );
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_valid <= 1'b0;
         result    <= '0;
         sticky    <= 1'b0;
      end else begin
         if (flush)    out_valid <= 1'b0;
         else if (adv) out_valid <= g_lvl[NUM_LEVELS-1].vld_in;
         if (adv) begin
            result <= g_lvl[NUM_LEVELS-1].d_out;
            sticky <= g_lvl[NUM_LEVELS-1].s_out;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_shifter.sv
// Bench for fp_align_shifter: directed vectors, stalls, random streaming against an arithmetic model,
// flush and asynchronous reset while beats are in flight.
module tb_fp_align_shifter;

   localparam int W  = 26;
   localparam int SW = 8;
   localparam int ND = 13;

   logic          clk = 1'b0;
   logic          nrst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  fraction = '0;
   logic [SW-1:0] shift_amount = '0;
   logic [1:0]    mode = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          sticky;

   int checks = 0;
   int errors = 0;
   logic [W:0] exp_q[$];

   logic [W-1:0]  d_frac [ND] = '{26'h3FFFFFF, 26'h2000010, 26'h2000010, 26'h0000001, 26'h0000001,
                                  26'h2000001, 26'h2000001, 26'h2000000, 26'h3FFFFFF, 26'h3FFFFFF,
                                  26'h2000000, 26'h0000001, 26'h2AAAAAA};
   logic [SW-1:0] d_sh   [ND] = '{8'd4, 8'd4, 8'd5, 8'd200, 8'd200, 8'd1, 8'd0, 8'd30, 8'd4, 8'd25,
                                  8'd26, 8'd25, 8'd0};
   logic [1:0]    d_mode [ND] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0,
                                  2'd0, 2'd2, 2'd1};
   logic [W-1:0]  d_res  [ND] = '{26'h03FFFFF, 26'h3E00001, 26'h3F00000, 26'h0000000, 26'h0000000,
                                  26'h0000002, 26'h2000001, 26'h3FFFFFF, 26'h03FFFFF, 26'h0000001,
                                  26'h0000000, 26'h2000000, 26'h2AAAAAA};
   logic          d_stk  [ND] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b1, 1'b0, 1'b0};

   fp_align_shifter #(
      .WIDTH    (W),
      .SHAMT_W  (SW),
      .REG_MASK (32'b00100)
   ) dut (
      .CLK          (clk),
      .nRST         (nrst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .fraction     (fraction),
      .shift_amount (shift_amount),
      .mode         (mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .sticky       (sticky)
   );

   always #5 clk = ~clk;

   // Whole-word shift arithmetic on a wide scratch value; returns {sticky, result}.
   function automatic logic [W:0] ref_model(logic [W-1:0] f, int sh, int m);
      logic [W-1:0] r;
      logic [W-1:0] ones;
      logic         s;
      logic [63:0]  wide;
      ones = '1;
      if (m == 3) m = 0;
      if (sh == 0) return {1'b0, f};
      if (sh >= W) begin
         if (m == 1) begin
            r = {W{f[W-1]}};
            s = |f[W-2:0];
         end else begin
            r = '0;
            s = |f;
         end
         return {s, r};
      end
      if (m == 2) begin
         wide = {38'b0, f} << sh;
         r    = wide[W-1:0];
         s    = |wide[63:W];
      end else begin
         wide = {f, 38'b0} >> sh;
         r    = wide[63:38];
         s    = |wide[37:0];
         if (m == 1 && f[W-1]) r = r | ~(ones >> sh);
      end
      return {s, r};
   endfunction

   // Samples the handshake just after the inputs settle, then runs to the next falling edge.
   task automatic step(output bit acc, output bit fire, output logic [W-1:0] r, output logic s,
                       output bit ov, output bit ir);
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      r    = result;
      s    = sticky;
      ov   = out_valid;
      ir   = in_ready;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 nrst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset result: got %h want 0", result); end
      checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL reset sticky: got %b want 0", sticky); end
      @(negedge clk);
      nrst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready_early: got %b want 0", in_ready); end
      @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready_late: got %b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_directed();
      bit acc, fire, ov, ir;
      logic [W-1:0] r;
      logic s;
      out_ready = 1'b1;
      for (int i = 0; i < ND; i++) begin
         fraction     = d_frac[i];
         shift_amount = d_sh[i];
         mode         = d_mode[i];
         in_valid     = 1'b1;
         step(acc, fire, r, s, ov, ir);
         checks++; if (!acc) begin errors++; $display("FAIL dir%0d accept: got %b want 1", i, acc); end
         in_valid = 1'b0;
         step(acc, fire, r, s, ov, ir);
         checks++; if (ov !== 1'b0) begin errors++; $display("FAIL dir%0d early_valid: got %b want 0", i, ov); end
         step(acc, fire, r, s, ov, ir);
         checks++; if (!fire) begin errors++; $display("FAIL dir%0d latency: out_valid %b want 1", i, ov); end
         checks++; if (r !== d_res[i]) begin errors++; $display("FAIL dir%0d result: got %h want %h", i, r, d_res[i]); end
         checks++; if (s !== d_stk[i]) begin errors++; $display("FAIL dir%0d sticky: got %b want %b", i, s, d_stk[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] want [4] = '{26'h0F0, 26'h078, 26'h03C, 26'h01E};
      int sent = 0;
      int got = 0;
      bit acc, fire, ov, ir;
      bit stalled = 1'b0;
      logic [W-1:0] r;
      logic [W-1:0] prev_r = '0;
      logic s;
      mode     = 2'd0;
      fraction = 26'h0F0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         in_valid     = (sent < 4);
         shift_amount = SW'(sent);
         out_ready    = !(c >= 3 && c < 6);
         step(acc, fire, r, s, ov, ir);
         if (stalled) begin
            checks++; if (r !== prev_r) begin errors++; $display("FAIL bp stable: got %h want %h", r, prev_r); end
         end
         if (ov && !out_ready) begin
            checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp in_ready_stall: got %b want 0", ir); end
         end
         stalled = ov && !out_ready;
         prev_r  = r;
         if (acc) sent++;
         if (fire) begin
            checks++; if (r !== want[got]) begin errors++; $display("FAIL bp result%0d: got %h want %h", got, r, want[got]); end
            checks++; if (s !== 1'b0) begin errors++; $display("FAIL bp sticky%0d: got %b want 0", got, s); end
            got++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++; if (got != 4) begin errors++; $display("FAIL bp count: got %0d want 4", got); end
   endtask

   task automatic test_random();
      bit acc, fire, ov, ir;
      bit stalled = 1'b0;
      logic [W-1:0] r;
      logic [W-1:0] prev_r = '0;
      logic s;
      logic prev_s = 1'b0;
      logic [W:0] e;
      int sent = 0;
      exp_q.delete();
      for (int c = 0; c < 4000 && (sent < 300 || exp_q.size() > 0); c++) begin
         in_valid     = (sent < 300) && ($urandom_range(0, 3) != 0);
         out_ready    = (sent >= 300) || ($urandom_range(0, 9) < 7);
         fraction     = W'($urandom);
         shift_amount = ($urandom_range(0, 4) == 0) ? SW'($urandom) : SW'($urandom_range(0, 30));
         mode         = 2'($urandom);
         step(acc, fire, r, s, ov, ir);
         if (stalled) begin
            checks++; if (r !== prev_r || s !== prev_s) begin errors++; $display("FAIL rnd stable: got %h/%b want %h/%b", r, s, prev_r, prev_s); end
         end
         stalled = ov && !out_ready;
         prev_r  = r;
         prev_s  = s;
         if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rnd spurious: got %h with empty queue", r);
            end else begin
               e = exp_q.pop_front();
               if ({s, r} !== e) begin errors++; $display("FAIL rnd data: got %b/%h want %b/%h", s, r, e[W], e[W-1:0]); end
            end
         end
         if (acc) begin
            exp_q.push_back(ref_model(fraction, int'(shift_amount), int'(mode)));
            sent++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++; if (exp_q.size() != 0 || sent != 300) begin errors++; $display("FAIL rnd drain: left %0d sent %0d want 0/300", exp_q.size(), sent); end
   endtask

   task automatic test_flush();
      bit acc, fire, ov, ir;
      logic [W-1:0] r;
      logic s;
      fraction     = 26'h1234567;
      shift_amount = 8'd2;
      mode         = 2'd0;
      in_valid     = 1'b1;
      out_ready    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(acc, fire, r, s, ov, ir);
         checks++; if (!acc) begin errors++; $display("FAIL flush accept%0d: got %b want 1", i, acc); end
      end
      flush = 1'b1;
      step(acc, fire, r, s, ov, ir);
      checks++; if (ir !== 1'b0) begin errors++; $display("FAIL flush in_ready: got %b want 0", ir); end
      checks++; if (acc) begin errors++; $display("FAIL flush dropped_beat: accepted %b want 0", acc); end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(acc, fire, r, s, ov, ir);
         checks++; if (ov !== 1'b0) begin errors++; $display("FAIL flush out_valid%0d: got %b want 0", i, ov); end
      end
   endtask

   task automatic test_reset_mid();
      bit acc, fire, ov, ir;
      bit seen = 1'b0;
      logic [W-1:0] r;
      logic s;
      logic [W:0] e;
      fraction     = 26'h3FFFFFF;
      shift_amount = 8'd3;
      mode         = 2'd0;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      repeat (2) step(acc, fire, r, s, ov, ir);
      in_valid = 1'b0;
      #2 nrst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL rst result: got %h want 0", result); end
      checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL rst sticky: got %b want 0", sticky); end
      @(negedge clk);
      nrst = 1'b1;
      step(acc, fire, r, s, ov, ir);
      checks++; if (ir !== 1'b0) begin errors++; $display("FAIL rst in_ready: got %b want 0", ir); end
      for (int i = 0; i < 6; i++) begin
         step(acc, fire, r, s, ov, ir);
         checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rst ghost%0d: got %b want 0", i, ov); end
      end
      fraction     = 26'h2345678;
      shift_amount = 8'd7;
      mode         = 2'd1;
      in_valid     = 1'b1;
      e            = ref_model(fraction, 7, 1);
      step(acc, fire, r, s, ov, ir);
      in_valid = 1'b0;
      checks++; if (!acc) begin errors++; $display("FAIL rst reaccept: got %b want 1", acc); end
      for (int i = 0; i < 6 && !seen; i++) begin
         step(acc, fire, r, s, ov, ir);
         if (fire) begin
            seen = 1'b1;
            checks++; if ({s, r} !== e) begin errors++; $display("FAIL rst data: got %b/%h want %b/%h", s, r, e[W], e[W-1:0]); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL rst timeout: got no output want one beat"); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
